// File: rtl/lsu_req_queue.sv
// lsu_req_queue: in-order request FIFO between LSU issue and the L1 data cache.
// Buffers core requests, presents the head entry to the cache, caps the number
// of requests the cache holds at once, and returns completions to the core one
// registered cycle after the cache reports them.
module lsu_req_queue #(
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        flush_in,
  input  logic        core_valid_in,
  output logic        core_ready_out,
  input  logic [63:0] core_addr_in,
  input  logic [63:0] core_value_in,
  input  logic        core_we_in,
  output logic        cache_valid_out,
  input  logic        cache_ready_in,
  output logic [63:0] cache_addr_out,
  output logic [63:0] cache_value_out,
  output logic        cache_we_out,
  input  logic        cache_valid_in,
  input  logic [63:0] cache_value_in,
  input  logic        cache_write_complete_in,
  output logic        core_valid_out,
  output logic [63:0] core_value_out,
  output logic        core_write_complete_out,
  output logic        misalign_err_out,
  output logic        protocol_err_out
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [OW-1:0] MAX_OS_C = OW'(MAX_OUTSTANDING);

  // Outstanding-count update; callers guarantee the result stays in 0..MAX.
  function automatic logic [OW-1:0] os_next(input logic [OW-1:0] cur,
                                            input logic          inc,
                                            input logic          dec_ld,
                                            input logic          dec_st);
    return cur + OW'(inc) - OW'(dec_ld) - OW'(dec_st);
  endfunction

  logic [63:0]      addr_mem  [DEPTH];
  logic [63:0]      value_mem [DEPTH];
  logic [DEPTH-1:0] we_mem;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [OW-1:0] os_q, os_d;
  logic          misalign_q, misalign_d;
  logic          protocol_err_q, protocol_err_d;
  logic          rsp_vld_q, rsp_vld_d;
  logic [63:0]   rsp_val_q, rsp_val_d;
  logic          wr_cmp_q, wr_cmp_d;

  logic not_empty;
  logic misaligned;
  logic enq_fire;
  logic push;
  logic pop;
  logic ld_ok;
  logic st_ok;

  assign not_empty  = (count_q != '0);
  assign misaligned = (core_addr_in[2:0] != 3'b000);

  // Ready is held low through reset so the core never sees a spurious accept.
  assign core_ready_out  = !rst_in && !flush_in && (count_q < DEPTH_C);
  assign enq_fire        = core_valid_in && core_ready_out;
  assign push            = enq_fire && !misaligned;

  assign cache_valid_out = !flush_in && not_empty && (os_q < MAX_OS_C);
  assign pop             = cache_valid_out && cache_ready_in;

  assign cache_addr_out  = not_empty ? addr_mem[rd_ptr_q]  : '0;
  assign cache_value_out = not_empty ? value_mem[rd_ptr_q] : '0;
  assign cache_we_out    = not_empty ? we_mem[rd_ptr_q]    : 1'b0;

  assign core_valid_out          = rsp_vld_q;
  assign core_value_out          = rsp_val_q;
  assign core_write_complete_out = wr_cmp_q;
  assign misalign_err_out        = misalign_q;
  assign protocol_err_out        = protocol_err_q;

  // Next-state for queue pointers, occupancy, outstanding count and responses.
  always_comb begin
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    if (flush_in) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
    // A completion only counts (and is forwarded) if something is in flight;
    // when a load and a store complete together, both need a live request.
    ld_ok          = cache_valid_in && (os_q != '0);
    st_ok          = cache_write_complete_in && (os_q > OW'(ld_ok));
    os_d           = os_next(os_q, pop, ld_ok, st_ok);
    protocol_err_d = protocol_err_q
                   | (cache_valid_in && !ld_ok)
                   | (cache_write_complete_in && !st_ok);
    misalign_d     = enq_fire && misaligned;
    rsp_vld_d      = ld_ok;
    wr_cmp_d       = st_ok;
    rsp_val_d      = ld_ok ? cache_value_in : rsp_val_q;
  end

  // Control and response registers.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      os_q           <= '0;
      misalign_q     <= 1'b0;
      protocol_err_q <= 1'b0;
      rsp_vld_q      <= 1'b0;
      rsp_val_q      <= '0;
      wr_cmp_q       <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      os_q           <= os_d;
      misalign_q     <= misalign_d;
      protocol_err_q <= protocol_err_d;
      rsp_vld_q      <= rsp_vld_d;
      rsp_val_q      <= rsp_val_d;
      wr_cmp_q       <= wr_cmp_d;
    end
  end

  // Entry storage; contents are only meaningful while count covers the slot.
  always_ff @(posedge clk_in) begin
    if (push) begin
      addr_mem[wr_ptr_q]  <= core_addr_in;
      value_mem[wr_ptr_q] <= core_value_in;
      we_mem[wr_ptr_q]    <= core_we_in;
    end
  end

endmodule

// File: doc/lsu_req_queue.md
Name: lsu_req_queue

Overview:
- In-order request buffer between the LSU issue logic and l1_data_cache; drives the cache's lsu_valid_in / lsu_addr_in / lsu_value_in / lsu_we_in port group.
- Decouples core issue from cache backpressure.
- Caps in-flight cache requests.
- Returns read data and write-complete pulses to the core, one registered cycle after the cache reports them.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2.
- MAX_OUTSTANDING, 4, maximum requests issued to cache and not yet completed; >= 1.

Ports:
- clk_in  input  1  clock; all state updates on rising edge.
- rst_in  input  1  asynchronous, active-high reset.
- flush_in  input  1  discard all queued, not-yet-issued entries.
- core_valid_in  input  1  core request valid.
- core_ready_out  output  1  queue can accept a request.
- core_addr_in  input  64  request byte address; must be 8-byte aligned.
- core_value_in  input  64  store data.
- core_we_in  input  1  1 = store, 0 = load.
- cache_valid_out  output  1  head entry presented to cache.
- cache_ready_in  input  1  cache accepts head entry.
- cache_addr_out  output  64  head address.
- cache_value_out  output  64  head store data.
- cache_we_out  output  1  head write enable.
- cache_valid_in  input  1  cache returns load data (one completion).
- cache_value_in  input  64  load data.
- cache_write_complete_in  input  1  cache completes one store.
- core_valid_out  output  1  load data valid, one-cycle pulse.
- core_value_out  output  64  load data.
- core_write_complete_out  output  1  store complete, one-cycle pulse.
- misalign_err_out  output  1  one-cycle pulse; a misaligned request was dropped.
- protocol_err_out  output  1  sticky; completion arrived with nothing outstanding.

Behaviour:
- Reset (async assert, sync release): FIFO count, pointers and outstanding counter go to 0. All outputs are 0, including core_ready_out, while rst_in is high.
- core_ready_out = (count < DEPTH) && !flush_in. It is combinational from registered count; there is no same-cycle bypass when full, even if a pop occurs.
- Enqueue on core_valid_in && core_ready_out.
  - If core_addr_in[2:0] != 0: the handshake completes, nothing is stored, and misalign_err_out pulses the next cycle.
- No fall-through: an entry enqueued in cycle N is first visible on cache_valid_out in cycle N+1.
- cache_valid_out = (count != 0) && (outstanding < MAX_OUTSTANDING). cache_addr/value/we_out always show the head entry; they are 0 when empty.
- Pop on cache_valid_out && cache_ready_in; outstanding increments by 1.
- Outstanding update per cycle is +issue, −cache_valid_in, −cache_write_complete_in. All three may coincide (net −1).
- Outstanding never goes below 0. A completion arriving with outstanding = 0 is ignored for counting and sets protocol_err_out until reset.
- Responses are registered:
  - core_valid_out and core_value_out follow cache_valid_in and cache_value_in by exactly 1 cycle.
  - core_write_complete_out follows cache_write_complete_in by 1 cycle.
  - core_value_out holds its last value when core_valid_out = 0.
- Simultaneous enqueue and pop in the same cycle: count unchanged, both pointers advance (mod DEPTH, natural wrap).
- flush_in:
  - In the flush cycle, no enqueue and no pop, and cache_valid_out is forced 0.
  - The next edge sets count and pointers to 0.
  - The outstanding counter and response path are unaffected; in-flight completions are still forwarded.
- Reset mid-operation: all queued and outstanding state is lost. No responses are forwarded after reset, even if the cache still returns them; those returns raise protocol_err_out.

Test Plan:
- Reset, then enqueue store 0x2000 / 0x12345678 with cache_ready_in = 1 -> cache_valid_out high the next cycle with addr 0x2000, we = 1. Assert cache_write_complete_in -> core_write_complete_out pulses exactly 1 cycle later.
- cache_ready_in = 0, enqueue 5 loads 0x1000, 0x1008, … -> core_ready_out drops after the 4th. Release ready -> cache sees the addresses in order, pointer wrap-around is verified, and the 5th load is accepted once space frees.
- MAX_OUTSTANDING = 4, issue 4 loads with no completions -> cache_valid_out stays 0 with entries queued. Return one cache_valid_in with 0xDEADBEEF -> core_value_out = 0xDEADBEEF the next cycle and the 5th request issues.
- Enqueue address 0x3004 -> misalign_err_out pulses once, cache_valid_out never asserts for it, and the queue stays empty.
- Queue 3 entries, assert flush_in for 1 cycle -> no pop occurs, count = 0 afterwards. A completion for an earlier issued load is still forwarded.
- Pulse cache_valid_in with nothing outstanding -> protocol_err_out = 1 and stays 1 until rst_in. Assert rst_in mid-burst -> all outputs go 0 immediately (asynchronous).
